register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file with rename tags.
- Sits directly downstream of the reorder buffer: it consumes the ROB commit port (rd, value, ROB index) and the misprediction flush.
- It is also the operand source for the dispatcher. The dispatcher reads rs1/rs2 value plus dependency tag, and writes a new rename tag when it issues an instruction with a destination.

Parameters:
- REG_WIDTH, 5, architectural register index width (32 registers)
- EX_REG_WIDTH, 6, register index width including the NON_REG code
- NON_REG, 32, rd/rs code meaning "no register"
- ROB_WIDTH, 4, ROB index width
- EX_ROB_WIDTH, 5, tag width including the NON_DEP code
- NON_DEP, 16, tag meaning "no pending producer"

Ports:
- Sys_clk  in  1  clock, rising edge
- Sys_rst  in  1  asynchronous, active-high reset
- Sys_rdy  in  1  global enable; state frozen when low
- DP2RF_rs1  in  EX_REG_WIDTH  source register 1 query
- DP2RF_rs2  in  EX_REG_WIDTH  source register 2 query
- RF2DP_Vj  out  32  rs1 value
- RF2DP_Vk  out  32  rs2 value
- RF2DP_Qj  out  EX_ROB_WIDTH  rs1 producer tag, NON_DEP if ready
- RF2DP_Qk  out  EX_ROB_WIDTH  rs2 producer tag, NON_DEP if ready
- DP2RF_en  in  1  rename request this cycle
- DP2RF_rd  in  EX_REG_WIDTH  destination being renamed
- DP2RF_ROB_index  in  ROB_WIDTH  ROB entry that will produce rd
- ROB2RF_en  in  1  commit valid
- ROB2RF_ROB_index  in  ROB_WIDTH  committing entry
- ROB2RF_rd  in  EX_REG_WIDTH  committing destination
- ROB2RF_value  in  32  committed value
- ROB2RF_pre_judge  in  1  high for one cycle on misprediction: flush all rename state

Behaviour:
- State: val[0..31] (32 b each) and tag[0..31] (EX_ROB_WIDTH each).
- Reset (async, Sys_rst=1): all val=0, all tag=NON_DEP. Outputs are combinational, so during reset they read Vj=Vk=0 and Qj=Qk=NON_DEP.
- Updates happen only on posedge Sys_clk with Sys_rdy=1 and Sys_rst=0. With Sys_rdy=0 every register holds its value.
- x0:
  - val[0] is always 0; writes to rd=0 are discarded.
  - Rename of rd=0 is ignored; tag[0] is always NON_DEP.
- rd=NON_REG (commit or rename) is ignored.
- Query (combinational, zero latency):
  - rs=NON_REG or rs=0 gives V=0, Q=NON_DEP.
  - Otherwise V=val[rs], Q=tag[rs], with bypass (below).
  - A query never sees a same-cycle rename. The dispatcher reads operands and renames the same instruction's rd in one cycle, so an instruction with rs1==rd sees the older producer.
- Commit bypass: if ROB2RF_en and ROB2RF_rd==rs and tag[rs]=={0,ROB2RF_ROB_index}, then V=ROB2RF_value and Q=NON_DEP in the same cycle.
- Commit write: val[rd] <= value. tag[rd] <= NON_DEP only if tag[rd] equals the committing index AND no same-cycle rename of the same rd.
- Rename: tag[rd] <= {0,DP2RF_ROB_index}. Rename wins over a same-cycle commit-clear of the same rd.
- Flush (ROB2RF_pre_judge=1):
  - All tags <= NON_DEP.
  - A same-cycle commit still writes val.
  - A same-cycle rename is discarded.
  - From the next cycle every query returns Q=NON_DEP.
- Tag wrap: ROB indices are reused modulo 16. A stale commit whose index does not match the current tag only updates val.

Optional Feature:
- RF_BYPASS_EN defined: the commit-to-query forwarding described above is present.
- Undefined: the query returns registered state only.
  - During a commit cycle, Q still shows the committing tag and V shows the old val.
  - The ROB must supply the value via its own Qj/Qk-ready path.
  - Registered behaviour is otherwise identical.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> Vj=0, Qj=16, Vk=0, Qk=16.
- Rename rd=3 to ROB 7; next cycle query rs1=3 -> Qj=7. Commit rd=3, idx 7, value 0xDEADBEEF -> same cycle Vj=0xDEADBEEF, Qj=16 (bypass on); next cycle registered val=0xDEADBEEF, tag=16.
- Rename x4 to idx 2, then rename x4 to idx 9; commit idx 2, value 0x11 -> val[4]=0x11, Qj for x4 stays 9.
- Same cycle: commit rd=6 idx 1 (tag 1) and rename rd=6 idx 5 -> tag[6]=5, val[6]=committed value.
- Rename x1..x3; assert ROB2RF_pre_judge with a rename of x8 and a commit of x2 value 0x42 -> next cycle all Q=16, val[2]=0x42, tag[8]=16. Writes to x0 leave Vj=0. Sys_rdy=0 blocks all updates.

Source files
------------

// File: rtl/register_file_if.sv
// Dispatcher / ROB side bus of the architectural register file.
// The register file takes the slave modport; the driving agent takes master.
interface register_file_if #(
  parameter int EX_REG_WIDTH = 6,
  parameter int ROB_WIDTH    = 4,
  parameter int EX_ROB_WIDTH = 5
);
  logic [EX_REG_WIDTH-1:0] DP2RF_rs1;
  logic [EX_REG_WIDTH-1:0] DP2RF_rs2;
  logic [31:0]             RF2DP_Vj;
  logic [31:0]             RF2DP_Vk;
  logic [EX_ROB_WIDTH-1:0] RF2DP_Qj;
  logic [EX_ROB_WIDTH-1:0] RF2DP_Qk;
  logic                    DP2RF_en;
  logic [EX_REG_WIDTH-1:0] DP2RF_rd;
  logic [ROB_WIDTH-1:0]    DP2RF_ROB_index;
  logic                    ROB2RF_en;
  logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index;
  logic [EX_REG_WIDTH-1:0] ROB2RF_rd;
  logic [31:0]             ROB2RF_value;
  logic                    ROB2RF_pre_judge;

  modport slave (
    input  DP2RF_rs1, DP2RF_rs2, DP2RF_en, DP2RF_rd, DP2RF_ROB_index,
    input  ROB2RF_en, ROB2RF_ROB_index, ROB2RF_rd, ROB2RF_value, ROB2RF_pre_judge,
    output RF2DP_Vj, RF2DP_Vk, RF2DP_Qj, RF2DP_Qk
  );

  modport master (
    output DP2RF_rs1, DP2RF_rs2, DP2RF_en, DP2RF_rd, DP2RF_ROB_index,
    output ROB2RF_en, ROB2RF_ROB_index, ROB2RF_rd, ROB2RF_value, ROB2RF_pre_judge,
    input  RF2DP_Vj, RF2DP_Vk, RF2DP_Qj, RF2DP_Qk
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags; combinational operand query, registered commit/rename/flush.
// Define RF_BYPASS_EN to forward a same-cycle matching commit onto the query ports.
module register_file #(
  parameter int REG_WIDTH    = 5,
  parameter int EX_REG_WIDTH = 6,
  parameter int NON_REG      = 32,
  parameter int ROB_WIDTH    = 4,
  parameter int EX_ROB_WIDTH = 5,
  parameter int NON_DEP      = 16
) (
  input  logic           Sys_clk,
  input  logic           Sys_rst,
  input  logic           Sys_rdy,
  register_file_if.slave bus
);
  localparam int NUM_REGS = 1 << REG_WIDTH;
  localparam logic [EX_ROB_WIDTH-1:0] TAG_NONE = EX_ROB_WIDTH'(NON_DEP);
  localparam logic [EX_REG_WIDTH-1:0] RD_NONE  = EX_REG_WIDTH'(NON_REG);

  typedef struct packed {
    logic [31:0]             v;
    logic [EX_ROB_WIDTH-1:0] q;
  } opnd_t;

  logic [31:0]             r_val [NUM_REGS];
  logic [EX_ROB_WIDTH-1:0] r_tag [NUM_REGS];

  // Codes outside the architectural range are treated like NON_REG; x0 is never live.
  function automatic logic f_live(input logic [EX_REG_WIDTH-1:0] r);
    return (r != RD_NONE) && (r < EX_REG_WIDTH'(NUM_REGS)) && (r != '0);
  endfunction

  logic                    w_cm_live;
  logic [REG_WIDTH-1:0]    w_cm_idx;
  logic [EX_ROB_WIDTH-1:0] w_cm_tag;
  logic                    w_rn_live;
  logic [REG_WIDTH-1:0]    w_rn_idx;
  logic [EX_ROB_WIDTH-1:0] w_rn_tag;

  assign w_cm_live = bus.ROB2RF_en && f_live(bus.ROB2RF_rd);
  assign w_cm_idx  = bus.ROB2RF_rd[REG_WIDTH-1:0];
  assign w_cm_tag  = EX_ROB_WIDTH'(bus.ROB2RF_ROB_index);
  assign w_rn_live = bus.DP2RF_en && f_live(bus.DP2RF_rd) && !bus.ROB2RF_pre_judge;
  assign w_rn_idx  = bus.DP2RF_rd[REG_WIDTH-1:0];
  assign w_rn_tag  = EX_ROB_WIDTH'(bus.DP2RF_ROB_index);

  logic [EX_REG_WIDTH-1:0] w_rs   [2];
  opnd_t                   w_opnd [2];

  assign w_rs[0] = bus.DP2RF_rs1;
  assign w_rs[1] = bus.DP2RF_rs2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_opnd[p].v = '0;
      w_opnd[p].q = TAG_NONE;
      if (f_live(w_rs[p])) begin
        w_opnd[p].v = r_val[w_rs[p][REG_WIDTH-1:0]];
        w_opnd[p].q = r_tag[w_rs[p][REG_WIDTH-1:0]];
`ifdef RF_BYPASS_EN
        if (bus.ROB2RF_en && (bus.ROB2RF_rd == w_rs[p]) && (w_opnd[p].q == w_cm_tag)) begin
          w_opnd[p].v = bus.ROB2RF_value;
          w_opnd[p].q = TAG_NONE;
        end
`endif
      end
    end
  end

  assign bus.RF2DP_Vj = w_opnd[0].v;
  assign bus.RF2DP_Qj = w_opnd[0].q;
  assign bus.RF2DP_Vk = w_opnd[1].v;
  assign bus.RF2DP_Qk = w_opnd[1].q;

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= TAG_NONE;
      end
    end else if (Sys_rdy) begin
      if (w_cm_live) begin
        r_val[w_cm_idx] <= bus.ROB2RF_value;
      end
      if (bus.ROB2RF_pre_judge) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          r_tag[i] <= TAG_NONE;
        end
      end else begin
        // Later assignment wins: a same-cycle rename overrides the commit clear.
        if (w_cm_live && (r_tag[w_cm_idx] == w_cm_tag)) begin
          r_tag[w_cm_idx] <= TAG_NONE;
        end
        if (w_rn_live) begin
          r_tag[w_rn_idx] <= w_rn_tag;
        end
      end
    end
  end
endmodule
